// File: rtl/gate_share_pkg.sv
// gate_share_pkg: shared state encoding and ID-width helper for the gate-sharing arbiter
package gate_share_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RESP = 1'b1;
  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/gate_share_arb_if.sv
// gate_share_arb_if: requester bundle and response channel between requesters and the arbiter
interface gate_share_arb_if import gate_share_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) ();
  logic [N_REQ-1:0] req_valid_i;
  logic [N_REQ-1:0] req_a_i;
  logic [N_REQ-1:0] req_b_i;
  logic [N_REQ-1:0] req_d_i;
  logic [N_REQ-1:0] req_ready_o;
  logic             rsp_valid_o;
  logic [ID_W-1:0]  rsp_id_o;
  logic             rsp_e_o;
  logic             rsp_ready_i;
  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_d_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_e_o
  );
  modport master (
    output req_valid_i, req_a_i, req_b_i, req_d_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_e_o
  );
endinterface

// File: rtl/gate_share_arb_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap
module rr_pick import gate_share_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);
  logic w_hit;
  // scan offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    w_hit = 1'b0;
    o_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N_REQ]) begin
        w_hit = 1'b1;
        o_idx = ID_W'((int'(i_ptr) + k) % N_REQ);
      end
    end
    o_any = i_en && w_hit;
    o_gnt = o_any ? (N_REQ'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/wire_not_use.sv
// wire_not_use: shared combinational gate unit, E = (A AND B) OR D
module wire_not_use (
  input  logic i_a,
  input  logic i_b,
  input  logic i_d,
  output logic o_e
);
  assign o_e = (i_a & i_b) | i_d;
endmodule

// File: rtl/gate_share_arb.sv
// gate_share_arb: round-robin sharing of one wire_not_use unit with a registered response channel
module gate_share_arb import gate_share_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  gate_share_arb_if.slave  bus
);
  localparam int ID_W = id_w(N_REQ);
  logic             r_state;
  logic             w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic             r_e;
  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [N_REQ-1:0] w_gnt;
  logic             w_en;
  logic             w_any;
  logic             w_e;
  assign w_en      = !rst_i && (r_state == ST_IDLE || bus.rsp_ready_i);
  assign w_ptr_nxt = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req (bus.req_valid_i),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );
  wire_not_use u_gate (
    .i_a (bus.req_a_i[w_idx]),
    .i_b (bus.req_b_i[w_idx]),
    .i_d (bus.req_d_i[w_idx]),
    .o_e (w_e)
  );
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end
  // a grant always lands in RESP; a retired response with no new grant returns to IDLE
  always_comb begin
    w_state_nxt = w_any ? ST_RESP : (r_state == ST_RESP && bus.rsp_ready_i) ? ST_IDLE : r_state;
  end
  // capture result, id and advance the pointer only on a grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_e   <= 1'b0;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
      r_id  <= w_idx;
      r_e   <= w_e;
    end
  end
  // drive the handshake outputs
  always_comb begin
    bus.req_ready_o = w_gnt;
    bus.rsp_valid_o = (r_state == ST_RESP);
    bus.rsp_id_o    = r_id;
    bus.rsp_e_o     = r_e;
  end
endmodule
